// File: rtl/pipe_hold_ctrl_pkg.sv
// Shared encodings for the pipeline hold controller: hold bus, address bus, FSM states.
// The hold-priority decode lives here so the top and any future users agree on it.
package pipe_hold_ctrl_pkg;

    localparam int unsigned HoldFlagW = 3;
    localparam int unsigned InstAddrW = 32;

    typedef logic [HoldFlagW-1:0] hold_flag_t;
    typedef logic [InstAddrW-1:0] inst_addr_t;

    localparam hold_flag_t HoldNone = 3'd0;
    localparam hold_flag_t HoldPc   = 3'd1;
    localparam hold_flag_t HoldIf   = 3'd2;
    localparam hold_flag_t HoldId   = 3'd3;

    localparam inst_addr_t ZeroWord = 32'h0000_0000;

    localparam logic [1:0] StRun    = 2'd0;
    localparam logic [1:0] StDrain  = 2'd1;
    localparam logic [1:0] StHalt   = 2'd2;
    localparam logic [1:0] StResume = 2'd3;

    function automatic hold_flag_t hold_decode(
        input logic [1:0] state,
        input logic       jump,
        input logic       hold_ex,
        input logic       hold_bus
    );
        hold_flag_t flag;
        if (state == StHalt || state == StResume) begin
            flag = HoldId;
        end else if (jump || hold_ex) begin
            flag = HoldId;
        end else if (state == StDrain) begin
            flag = HoldIf;
        end else if (hold_bus) begin
            flag = HoldPc;
        end else begin
            flag = HoldNone;
        end
        return flag;
    endfunction

endpackage

// File: rtl/hold_sat_counter.sv
// Saturating up-counter with synchronous clear; clear takes priority over enable.
module hold_sat_counter #(
    parameter int unsigned W   = 8,
    parameter int unsigned MAX = 16
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         clr_i,
    input  logic         en_i,
    output logic [W-1:0] cnt_o
);

    localparam logic [W-1:0] MaxVal = W'(MAX);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q < MaxVal)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_hold_ctrl.sv
// Pipeline hold/flush controller with debug-halt handshake and sticky bus-stall timeout.
// Optional perf counters (stall_cnt_o, flush_cnt_o) are built when PIPE_HOLD_CTRL_PERF_EN is defined.
module pipe_hold_ctrl
    import pipe_hold_ctrl_pkg::*;
#(
    parameter int unsigned BUS_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        jump_flag_i,
    input  logic [31:0] jump_addr_i,
    input  logic        hold_ex_i,
    input  logic        hold_bus_i,
    input  logic        halt_req_i,
    input  logic        timeout_clr_i,
    output logic [2:0]  hold_flag_o,
    output logic        jump_flag_o,
    output logic [31:0] jump_addr_o,
    output logic        halt_ack_o,
    output logic        bus_timeout_o
`ifdef PIPE_HOLD_CTRL_PERF_EN
    ,
    output logic [31:0] stall_cnt_o,
    output logic [31:0] flush_cnt_o
`endif
);

    logic [1:0]       state_q, state_d;
    hold_flag_t       hold_flag;
    logic [CNT_W-1:0] bus_cnt;
    logic             bus_at_max;
    logic             timeout_q, timeout_d;

    always_comb begin
        state_d = state_q;
        case (state_q)
            StRun: begin
                if (halt_req_i) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                // An abandoned request wins over a drain that would complete this cycle.
                if (!halt_req_i) begin
                    state_d = StRun;
                end else if (!hold_ex_i && !jump_flag_i) begin
                    state_d = StHalt;
                end
            end
            StHalt: begin
                if (!halt_req_i) begin
                    state_d = StResume;
                end
            end
            StResume: begin
                state_d = halt_req_i ? StDrain : StRun;
            end
            default: state_d = StRun;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StRun;
        end else begin
            state_q <= state_d;
        end
    end

    assign hold_flag = hold_decode(state_q, jump_flag_i, hold_ex_i, hold_bus_i);

    // Combinational outputs are forced low while reset is held.
    assign hold_flag_o = rst ? hold_flag : HoldNone;
    assign jump_flag_o = rst & jump_flag_i;
    assign jump_addr_o = (rst && jump_flag_i) ? jump_addr_i : ZeroWord;
    assign halt_ack_o  = (state_q == StHalt);

    hold_sat_counter #(
        .W   (CNT_W),
        .MAX (BUS_TIMEOUT)
    ) u_bus_cnt (
        .clk_i  (clk),
        .rst_ni (rst),
        .clr_i  (~hold_bus_i),
        .en_i   (hold_bus_i),
        .cnt_o  (bus_cnt)
    );

    assign bus_at_max = (bus_cnt == CNT_W'(BUS_TIMEOUT));

    always_comb begin
        timeout_d = timeout_q;
        if (bus_at_max) begin
            timeout_d = 1'b1;
        end else if (timeout_clr_i) begin
            timeout_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= timeout_d;
        end
    end

    assign bus_timeout_o = timeout_q;

`ifdef PIPE_HOLD_CTRL_PERF_EN
    logic [31:0] stall_cnt_q, flush_cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else if (!halt_ack_o) begin
            if ((state_q == StRun) && (hold_flag != HoldNone)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (jump_flag_i) begin
                flush_cnt_q <= flush_cnt_q + 32'd1;
            end
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_hold_ctrl.sv
// Directed self-checking bench for pipe_hold_ctrl (default build, BUS_TIMEOUT=16).
module tb_pipe_hold_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        jump_flag_i;
    logic [31:0] jump_addr_i;
    logic        hold_ex_i;
    logic        hold_bus_i;
    logic        halt_req_i;
    logic        timeout_clr_i;
    logic [2:0]  hold_flag_o;
    logic        jump_flag_o;
    logic [31:0] jump_addr_o;
    logic        halt_ack_o;
    logic        bus_timeout_o;

    int checks = 0;
    int errors = 0;

    pipe_hold_ctrl #(
        .BUS_TIMEOUT (16),
        .CNT_W       (8)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .jump_flag_i   (jump_flag_i),
        .jump_addr_i   (jump_addr_i),
        .hold_ex_i     (hold_ex_i),
        .hold_bus_i    (hold_bus_i),
        .halt_req_i    (halt_req_i),
        .timeout_clr_i (timeout_clr_i),
        .hold_flag_o   (hold_flag_o),
        .jump_flag_o   (jump_flag_o),
        .jump_addr_o   (jump_addr_o),
        .halt_ack_o    (halt_ack_o),
        .bus_timeout_o (bus_timeout_o)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_flag(input string name, input logic [2:0] exp);
        checks++;
        if (hold_flag_o !== exp) begin
            errors++;
            $display("FAIL %s hold_flag_o got %0d want %0d", name, hold_flag_o, exp);
        end
    endtask

    task automatic chk_ack(input string name, input logic exp);
        checks++;
        if (halt_ack_o !== exp) begin
            errors++;
            $display("FAIL %s halt_ack_o got %0b want %0b", name, halt_ack_o, exp);
        end
    endtask

    task automatic chk_to(input string name, input logic exp);
        checks++;
        if (bus_timeout_o !== exp) begin
            errors++;
            $display("FAIL %s bus_timeout_o got %0b want %0b", name, bus_timeout_o, exp);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        jump_flag_i = 1'b1; jump_addr_i = 32'hDEAD_BEEF;
        hold_ex_i = 1'b1; hold_bus_i = 1'b0; halt_req_i = 1'b0; timeout_clr_i = 1'b0;
        cyc(); cyc();
        chk_flag("rst_hold_flag", 3'd0);
        checks++;
        if (jump_flag_o !== 1'b0 || jump_addr_o !== 32'h0) begin
            errors++;
            $display("FAIL rst_jump got %0b/%h want 0/0", jump_flag_o, jump_addr_o);
        end
        jump_flag_i = 1'b0; jump_addr_i = 32'h0; hold_ex_i = 1'b0;
        #2 rst = 1'b1;
        cyc();
        chk_flag("post_rst_flag", 3'd0);
        chk_ack("post_rst_ack", 1'b0);
        chk_to("post_rst_to", 1'b0);
    endtask

    task automatic test_jump();
        jump_flag_i = 1'b1; jump_addr_i = 32'h0000_0100; hold_bus_i = 1'b1;
        #1;
        chk_flag("jump_over_bus", 3'd3);
        checks++;
        if (jump_flag_o !== 1'b1 || jump_addr_o !== 32'h0000_0100) begin
            errors++;
            $display("FAIL jump_pass got %0b/%h want 1/00000100", jump_flag_o, jump_addr_o);
        end
        jump_flag_i = 1'b0;
        #1;
        checks++;
        if (jump_addr_o !== 32'h0) begin
            errors++;
            $display("FAIL jump_addr_zero got %h want 00000000", jump_addr_o);
        end
        chk_flag("bus_only", 3'd1);
        hold_ex_i = 1'b1;
        #1;
        chk_flag("ex_over_bus", 3'd3);
        hold_ex_i = 1'b0; hold_bus_i = 1'b0; jump_addr_i = 32'h0;
        cyc();
        chk_flag("jump_idle", 3'd0);
    endtask

    task automatic test_halt();
        halt_req_i = 1'b1; hold_ex_i = 1'b1;
        #1;
        chk_flag("halt_run_ex", 3'd3);
        cyc();
        chk_flag("drain_ex1", 3'd3);
        chk_ack("drain_ex1_ack", 1'b0);
        cyc();
        chk_flag("drain_ex2", 3'd3);
        cyc();
        hold_ex_i = 1'b0;
        #1;
        chk_flag("drain_if", 3'd2);
        chk_ack("drain_if_ack", 1'b0);
        cyc();
        chk_ack("halt_ack", 1'b1);
        chk_flag("halt_flag", 3'd3);
        hold_bus_i = 1'b1;
        #1;
        chk_flag("halt_bus", 3'd3);
        hold_bus_i = 1'b0;
        halt_req_i = 1'b0;
        cyc();
        chk_ack("resume_ack", 1'b0);
        chk_flag("resume_flag", 3'd3);
        cyc();
        chk_flag("resume_done", 3'd0);
    endtask

    task automatic test_drain_abort();
        halt_req_i = 1'b1;
        cyc();
        chk_flag("abort_drain", 3'd2);
        jump_flag_i = 1'b1; jump_addr_i = 32'h0000_0200;
        #1;
        chk_flag("abort_jump", 3'd3);
        checks++;
        if (jump_addr_o !== 32'h0000_0200) begin
            errors++;
            $display("FAIL drain_jump_addr got %h want 00000200", jump_addr_o);
        end
        cyc();
        jump_flag_i = 1'b0; jump_addr_i = 32'h0;
        #1;
        chk_flag("abort_wait", 3'd2);
        chk_ack("abort_wait_ack", 1'b0);
        halt_req_i = 1'b0;
        cyc();
        chk_flag("abort_run", 3'd0);
        chk_ack("abort_run_ack", 1'b0);
        cyc();
        chk_ack("abort_noack", 1'b0);
    endtask

    task automatic test_resume_rehalt();
        halt_req_i = 1'b1;
        cyc(); cyc();
        chk_ack("rehalt_ack1", 1'b1);
        halt_req_i = 1'b0;
        cyc();
        chk_flag("rehalt_resume", 3'd3);
        halt_req_i = 1'b1;
        cyc();
        chk_flag("rehalt_drain", 3'd2);
        chk_ack("rehalt_drain_ack", 1'b0);
        cyc();
        chk_ack("rehalt_ack2", 1'b1);
        halt_req_i = 1'b0;
        cyc(); cyc();
        chk_flag("rehalt_run", 3'd0);
    endtask

    task automatic test_bus_timeout();
        int bad;
        hold_bus_i = 1'b1;
        bad = 0;
        for (int i = 0; i < 16; i++) begin
            #1;
            if (hold_flag_o !== 3'd1) bad++;
            cyc();
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL bus16_flag got %0d bad cycles want 0", bad);
        end
        hold_bus_i = 1'b0;
        cyc();
        chk_to("bus16_timeout", 1'b1);
        chk_flag("bus16_released", 3'd0);
        cyc(); cyc();
        chk_to("bus16_sticky", 1'b1);
        timeout_clr_i = 1'b1;
        cyc();
        timeout_clr_i = 1'b0;
        chk_to("bus_clr", 1'b0);
        hold_bus_i = 1'b1;
        for (int i = 0; i < 15; i++) cyc();
        hold_bus_i = 1'b0;
        cyc(); cyc(); cyc();
        chk_to("bus15_no_timeout", 1'b0);
        hold_bus_i = 1'b1;
        for (int i = 0; i < 18; i++) cyc();
        timeout_clr_i = 1'b1;
        cyc();
        chk_to("bus_set_wins", 1'b1);
        timeout_clr_i = 1'b0;
        hold_bus_i = 1'b0;
        cyc();
        timeout_clr_i = 1'b1;
        cyc();
        timeout_clr_i = 1'b0;
        chk_to("bus_clr2", 1'b0);
    endtask

    task automatic test_async_reset();
        halt_req_i = 1'b1;
        cyc(); cyc();
        chk_ack("areset_halted", 1'b1);
        #2 rst = 1'b0;
        #1;
        chk_ack("areset_ack_drop", 1'b0);
        chk_flag("areset_flag", 3'd0);
        halt_req_i = 1'b0;
        cyc();
        #2 rst = 1'b1;
        cyc();
        chk_flag("areset_run_flag", 3'd0);
        chk_ack("areset_run_ack", 1'b0);
        chk_to("areset_to", 1'b0);
        hold_bus_i = 1'b1;
        #1;
        chk_flag("areset_run_bus", 3'd1);
        hold_bus_i = 1'b0;
        cyc();
    endtask

    initial begin
        test_reset();
        test_jump();
        test_halt();
        test_drain_abort();
        test_resume_rehalt();
        test_bus_timeout();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
